adder_approx_pipe: RTL and testbench

ADDER_APPROX_PIPE -- requirements
Module: adder_approx_pipe

---
 rtl/adder_approx_pipe.sv | 218 +++++++++++++++++++++
 tb/tb_adder_approx_pipe.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_approx_pipe.sv
// adder_approx_pipe: two-stage pipelined Brent-Kung adder with an optional
// approximate low region (bits 0..K-1 ignore carry chains longer than one bit).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          operand beat handshake (a, b, cin, mode)
//   out_valid/out_ready        result handshake (sum, cout, err)
//   err_cnt, err_clr           saturating count of delivered err results, sync clear
module adder_approx_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned K     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             err,
  output logic [15:0]      err_cnt,
  input  logic             err_clr
);

  localparam int unsigned LVL     = $clog2(WIDTH);
  localparam int unsigned CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Brent-Kung up-sweep: returns {g, p} with power-of-two group spans resolved.
  function automatic logic [2*WIDTH-1:0] bk_up(input logic [WIDTH-1:0] g_in,
                                               input logic [WIDTH-1:0] p_in);
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    g = g_in;
    p = p_in;
    for (int l = 0; l < int'(LVL); l++) begin
      for (int i = (2 << l) - 1; i < int'(WIDTH); i += (2 << l)) begin
        g[i] = g[i] | (p[i] & g[i - (1 << l)]);
        p[i] = p[i] & p[i - (1 << l)];
      end
    end
    return {g, p};
  endfunction

  // Brent-Kung down-sweep: completes every position to a full prefix carry.
  function automatic logic [WIDTH-1:0] bk_down(input logic [WIDTH-1:0] g_in,
                                               input logic [WIDTH-1:0] p_in);
    logic [WIDTH-1:0] g;
    g = g_in;
    for (int l = int'(LVL) - 2; l >= 0; l--) begin
      for (int i = (3 << l) - 1; i < int'(WIDTH); i += (2 << l)) begin
        g[i] = g[i] | (p_in[i] & g[i - (1 << l)]);
      end
    end
    return g;
  endfunction

  // Stage registers
  logic               alive_q;
  logic               s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               cin_q, cin_d, mode_q, mode_d;
  logic [2*WIDTH-1:0] up_e_q, up_e_d, up_a_q, up_a_d;
  logic               s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d, err_q, err_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic s1_load, s2_load, out_xfer;

  // Handshake: S2 refills whenever it is empty or draining this cycle.
  always_comb begin
    s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
    in_ready = alive_q && (!s1_valid_q || s2_load);
    s1_load  = in_valid && in_ready;
    out_xfer = s2_valid_q && out_ready;
  end

  // Stage 1 datapath: exact vector folds cin into bit 0; approximate vector
  // zeroes the low region except the seed generate at bit K-1.
  logic [WIDTH-1:0]   g1, p1, ge1, ga1, pa1;
  logic [2*WIDTH-1:0] up_e_c, up_a_c;
  always_comb begin
    g1     = a & b;
    p1     = a ^ b;
    ge1    = g1;
    ge1[0] = g1[0] | (p1[0] & cin);
    ga1    = '0;
    pa1    = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (i >= int'(K)) begin
        ga1[i] = g1[i];
        pa1[i] = p1[i];
      end else if (i == int'(K) - 1) begin
        ga1[i] = g1[i];
      end
    end
    if (K == 0) ga1[0] = g1[0] | (p1[0] & cin);
    up_e_c = bk_up(ge1, p1);
    up_a_c = bk_up(ga1, pa1);
  end

  // Stage 2 datapath: finish both prefix trees, form sums and the err flag.
  logic [WIDTH-1:0] p2, ge2, ga2, ce2, gsh2, gash2, ca2, sum_e, sum_a;
  logic [WIDTH-2:0] g2_lo;
  logic             cout_e, cout_a;
  always_comb begin
    p2     = a_q ^ b_q;
    g2_lo  = a_q[WIDTH-2:0] & b_q[WIDTH-2:0];
    ge2    = bk_down(up_e_q[2*WIDTH-1:WIDTH], up_e_q[WIDTH-1:0]);
    ga2    = bk_down(up_a_q[2*WIDTH-1:WIDTH], up_a_q[WIDTH-1:0]);
    ce2    = {ge2[WIDTH-2:0], cin_q};
    gsh2   = {g2_lo, 1'b0};
    gash2  = {ga2[WIDTH-2:0], cin_q};
    ca2    = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      ca2[i] = (i < int'(K)) ? gsh2[i] : gash2[i];
    end
    sum_e  = p2 ^ ce2;
    cout_e = ge2[WIDTH-1];
    sum_a  = p2 ^ ca2;
    cout_a = ga2[WIDTH-1];
  end

  // Next-state for both stages and the error counter.
  always_comb begin
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    cin_d      = cin_q;
    mode_d     = mode_q;
    up_e_d     = up_e_q;
    up_a_d     = up_a_q;
    s2_valid_d = s2_valid_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    err_d      = err_q;
    err_cnt_d  = err_cnt_q;

    if (s1_load) begin
      s1_valid_d = 1'b1;
      a_d        = a;
      b_d        = b;
      cin_d      = cin;
      mode_d     = mode;
      up_e_d     = up_e_c;
      up_a_d     = up_a_c;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      s2_valid_d = 1'b1;
      if (mode_q) begin
        sum_d  = sum_a;
        cout_d = cout_a;
        err_d  = {cout_a, sum_a} != {cout_e, sum_e};
      end else begin
        sum_d  = sum_e;
        cout_d = cout_e;
        err_d  = 1'b0;
      end
    end else if (out_xfer) begin
      s2_valid_d = 1'b0;
    end

    // Clear has priority over a same-cycle increment.
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (out_xfer && err_q && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_q    <= 1'b0;
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      mode_q     <= 1'b0;
      up_e_q     <= '0;
      up_a_q     <= '0;
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      alive_q    <= 1'b1;
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cin_q      <= cin_d;
      mode_q     <= mode_d;
      up_e_q     <= up_e_d;
      up_a_q     <= up_a_d;
      s2_valid_q <= s2_valid_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_adder_approx_pipe.sv
// Bench for adder_approx_pipe (WIDTH=16, K=8): directed vectors, backpressure,
// randomized streaming against an arithmetic reference, counter and reset.
module tb_adder_approx_pipe;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned K     = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin, mode;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout, err;
  logic [15:0]      err_cnt;
  logic             err_clr;

  int          checks = 0;
  int          errors = 0;
  logic [17:0] exp_q[$];
  logic [15:0] exp_cnt;

  adder_approx_pipe #(.WIDTH(WIDTH), .K(K)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .err(err),
    .err_cnt(err_cnt), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact is plain addition; approximate low byte is p ^ (g << 1),
  // high byte is a plain add seeded by g[K-1]. Result packed {err, cout, sum}.
  function automatic logic [17:0] model(input logic [15:0] ia, input logic [15:0] ib,
                                        input logic ic, input logic im);
    logic [16:0] ex, ap;
    logic [7:0]  lo;
    logic [8:0]  hi;
    logic        cy;
    ex = {1'b0, ia} + {1'b0, ib} + 17'(ic);
    lo = (ia[7:0] ^ ib[7:0]) ^ {ia[6:0] & ib[6:0], 1'b0};
    cy = ia[7] & ib[7];
    hi = {1'b0, ia[15:8]} + {1'b0, ib[15:8]} + 9'(cy);
    ap = {hi, lo};
    if (!im) return {1'b0, ex};
    return {(ap != ex), ap};
  endfunction

  function automatic logic [15:0] cnt_next(input logic [15:0] c, input logic e, input logic clr);
    if (clr) return 16'h0;
    if (e && c != 16'hFFFF) return c + 16'd1;
    return c;
  endfunction

  // Drives one cycle from a negedge, samples #1 later, returns at the next negedge.
  task automatic cycle(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                       input logic ic, input logic im, input logic ordy, input logic clr,
                       output logic acc, output logic ov, output logic ir,
                       output logic [17:0] obs);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    cin       = ic;
    mode      = im;
    out_ready = ordy;
    err_clr   = clr;
    #1;
    acc = in_valid && in_ready;
    ov  = out_valid;
    ir  = in_ready;
    obs = {err, cout, sum};
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; mode = 1'b0;
    out_ready = 1'b0; err_clr = 1'b0;
    exp_cnt = 16'h0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if ({err, cout, sum} !== 18'h0) begin errors++; $display("FAIL reset_result got %h want 0", {err, cout, sum}); end
    checks++; if (err_cnt !== 16'h0) begin errors++; $display("FAIL reset_err_cnt got %h want 0", err_cnt); end
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [15:0] va [9] = '{16'h1234, 16'h1234, 16'h00FF, 16'h00FF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0080};
    logic [15:0] vb [9] = '{16'h0F0F, 16'h0F0F, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0080};
    logic        vc [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        vm [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [17:0] ve [9] = '{18'h02143, 18'h22133, 18'h200FC, 18'h00100, 18'h10000,
                            18'h2FFFC, 18'h10000, 18'h2FFFF, 18'h00100};
    logic acc, ov, ir;
    logic [17:0] obs;
    for (int j = 0; j < 9; j++) begin
      cycle(1'b1, va[j], vb[j], vc[j], vm[j], 1'b1, 1'b0, acc, ov, ir, obs);
      checks++; if (acc !== 1'b1) begin errors++; $display("FAIL dir%0d_accept got %b want 1", j, acc); end
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, acc, ov, ir, obs);
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL dir%0d_early_valid got %b want 0", j, ov); end
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, acc, ov, ir, obs);
      checks++;
      if (ov !== 1'b1 || obs !== ve[j]) begin
        errors++; $display("FAIL dir%0d_result valid %b got %h want %h", j, ov, obs, ve[j]);
      end
      exp_cnt = cnt_next(exp_cnt, ve[j][17], 1'b0);
    end
    checks++; if (err_cnt !== exp_cnt) begin errors++; $display("FAIL dir_err_cnt got %h want %h", err_cnt, exp_cnt); end
  endtask

  task automatic test_backpressure();
    logic [15:0] ba [4];
    logic [15:0] bb [4];
    logic        bm [4];
    logic acc, ov, ir;
    logic [17:0] obs, h;
    int idx = 0;
    int got = 0;
    for (int j = 0; j < 4; j++) begin
      ba[j] = 16'($urandom); bb[j] = 16'($urandom); bm[j] = 1'($urandom);
    end
    for (int cyc = 0; cyc < 20; cyc++) begin
      cycle(idx < 4, ba[idx % 4], bb[idx % 4], 1'b0, bm[idx % 4], cyc >= 4, 1'b0, acc, ov, ir, obs);
      if (cyc == 2 || cyc == 3) begin
        checks++;
        if (ir !== 1'b0 || idx != 2) begin
          errors++; $display("FAIL bp_stall cyc%0d in_ready %b beats %0d want 0 and 2", cyc, ir, idx);
        end
      end
      if (ov) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_spurious got %h want nothing", obs);
        end else if (obs !== exp_q[0]) begin
          errors++; $display("FAIL bp_result cyc%0d got %h want %h", cyc, obs, exp_q[0]);
        end
        if (cyc >= 4 && exp_q.size() != 0) begin
          h = exp_q.pop_front(); got++;
          exp_cnt = cnt_next(exp_cnt, h[17], 1'b0);
        end
      end
      if (acc) begin
        exp_q.push_back(model(ba[idx], bb[idx], 1'b0, bm[idx]));
        idx++;
      end
    end
    checks++;
    if (got != 4 || exp_q.size() != 0) begin
      errors++; $display("FAIL bp_delivered got %0d pending %0d want 4 and 0", got, exp_q.size());
    end
  endtask

  task automatic test_random();
    logic acc, ov, ir, iv, ordy, ic, im;
    logic [15:0] ra, rb;
    logic [17:0] obs, h;
    for (int cyc = 0; cyc < 420; cyc++) begin
      iv   = (cyc < 400) && ($urandom_range(0, 9) < 7);
      ordy = (cyc >= 400) || ($urandom_range(0, 9) < 7);
      ra   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      rb   = ($urandom_range(0, 7) == 0) ? 16'h0001 : 16'($urandom);
      ic   = 1'($urandom);
      im   = 1'($urandom);
      cycle(iv, ra, rb, ic, im, ordy, 1'b0, acc, ov, ir, obs);
      if (ov) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rnd_spurious cyc%0d got %h want nothing", cyc, obs);
        end else if (obs !== exp_q[0]) begin
          errors++; $display("FAIL rnd_result cyc%0d got %h want %h", cyc, obs, exp_q[0]);
        end
        if (ordy && exp_q.size() != 0) begin
          h = exp_q.pop_front();
          exp_cnt = cnt_next(exp_cnt, h[17], 1'b0);
        end
      end
      if (acc) exp_q.push_back(model(ra, rb, ic, im));
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_drain pending %0d want 0", exp_q.size()); end
    checks++; if (err_cnt !== exp_cnt) begin errors++; $display("FAIL rnd_err_cnt got %h want %h", err_cnt, exp_cnt); end
  endtask

  task automatic test_err_counter();
    logic acc, ov, ir, clr;
    logic [17:0] obs;
    force dut.err_cnt_q = 16'hFFFD;
    #1;
    release dut.err_cnt_q;
    exp_cnt = 16'hFFFD;
    // Four error beats back to back: counter must stop at 0xFFFF.
    for (int k = 0; k < 7; k++) begin
      cycle(k < 4, 16'h00FF, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0, acc, ov, ir, obs);
      if (ov) exp_cnt = cnt_next(exp_cnt, 1'b1, 1'b0);
      checks++; if (err_cnt !== exp_cnt) begin errors++; $display("FAIL sat_cnt step%0d got %h want %h", k, err_cnt, exp_cnt); end
    end
    // Clear on the same cycle as an error transfer, then resume counting.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) begin
        clr = (r == 0) && (k == 2);
        cycle(k == 0, 16'h00FF, 16'h0001, 1'b0, 1'b1, 1'b1, clr, acc, ov, ir, obs);
        if (ov) exp_cnt = cnt_next(exp_cnt, obs[17], clr);
      end
      checks++; if (err_cnt !== exp_cnt) begin errors++; $display("FAIL clr_cnt round%0d got %h want %h", r, err_cnt, exp_cnt); end
    end
  endtask

  task automatic test_reset_midstream();
    logic acc, ov, ir;
    logic [17:0] obs;
    cycle(1'b1, 16'h1234, 16'h0F0F, 1'b0, 1'b1, 1'b0, 1'b0, acc, ov, ir, obs);
    cycle(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, acc, ov, ir, obs);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready got %b want 0", in_ready); end
    checks++; if ({err, cout, sum, err_cnt} !== 34'h0) begin errors++; $display("FAIL mid_rst_state got %h want 0", {err, cout, sum, err_cnt}); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_cnt = 16'h0;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, acc, ov, ir, obs);
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL mid_rst_discard step%0d got %b want 0", k, ov); end
      if (k == 1) begin
        checks++; if (ir !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %b want 1", ir); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_err_counter();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
